// File: rtl/video_timing_pkg.sv
// Shared types and constants for the HDMI raster timing sequencer.
package video_timing_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned CNT_W = 11;

    // Bit positions inside the { display_enable, vsync, hsync } bundle.
    localparam int unsigned SB_W  = 3;
    localparam int unsigned SB_DE = 2;
    localparam int unsigned SB_VS = 1;
    localparam int unsigned SB_HS = 0;

    // 640x480@60 raster.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a reset pattern; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int unsigned  W       = 3,
    parameter int unsigned  DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [W-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing sequencer: h/v counters, frame-boundary start/stop FSM,
// pixel request decode and a latency-matched sync bundle for the encoder.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic             hdmi_clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             running,
    output logic             pixel_req,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [SB_W-1:0]  hve_sync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    localparam logic [SB_W-1:0] IDLE_PAT = {1'b0, ~VSYNC_POL, ~HSYNC_POL};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_run;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_de;
    logic             w_hs_act;
    logic             w_vs_act;
    logic [SB_W-1:0]  w_sync;

    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    assign w_h_last = (r_h == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_v == CNT_W'(V_TOTAL - 1));

    // enable is only consulted on entry from IDLE and on the last clock of a frame.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        case (r_state)
            IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_h_last) begin
                    w_h_nxt = '0;
                    if (w_v_last) begin
                        w_v_nxt = '0;
                        if (!enable) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_v_nxt = r_v + CNT_W'(1);
                    end
                end else begin
                    w_h_nxt = r_h + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_h_nxt     = '0;
                w_v_nxt     = '0;
            end
        endcase
    end

    assign w_run    = (r_state == RUN);
    assign w_de     = w_run && (32'(r_h) < H_ACTIVE) && (32'(r_v) < V_ACTIVE);
    assign w_hs_act = w_run && (32'(r_h) >= HS_BEG) && (32'(r_h) < HS_END);
    assign w_vs_act = w_run && (32'(r_v) >= VS_BEG) && (32'(r_v) < VS_END);

    always_comb begin
        w_sync        = IDLE_PAT;
        w_sync[SB_DE] = w_de;
        w_sync[SB_VS] = w_vs_act ? VSYNC_POL : ~VSYNC_POL;
        w_sync[SB_HS] = w_hs_act ? HSYNC_POL : ~HSYNC_POL;
    end

    assign running     = w_run;
    assign pixel_req   = w_de;
    assign x           = r_h;
    assign y           = r_v;
    assign line_start  = w_run && (r_h == '0) && (32'(r_v) < V_ACTIVE);
    assign frame_start = w_run && (r_h == '0) && (r_v == '0);

    // Keeps the sync bundle aligned with RGB returned by the pixel source.
    sync_delay_line #(
        .W       (SB_W),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (IDLE_PAT)
    ) u_sync_dly (
        .i_clk   (hdmi_clk),
        .i_rst_n (reset_n),
        .i_d     (w_sync),
        .o_q     (hve_sync)
    );

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on an 8x6 raster with 2-clock sync latency.
module tb_video_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        running;
    logic        pixel_req;
    logic [10:0] x;
    logic [10:0] y;
    logic        line_start;
    logic        frame_start;
    logic [2:0]  hve_sync;

    int checks = 0;
    int errors = 0;

    video_timing_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .PIPE_LAT (2)
    ) dut (
        .hdmi_clk    (clk),
        .reset_n     (rst_n),
        .enable      (en),
        .running     (running),
        .pixel_req   (pixel_req),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hve_sync    (hve_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        run;
        logic        pr;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic [2:0]  hve;
    } vec_t;

    vec_t vecs[11];

    // Per-cycle log of the first RUN frame, sampled on the falling edge.
    logic       acc_en = 1'b0;
    int         acc_cyc = 0;
    int         pr_cnt = 0;
    int         ls_cnt = 0;
    logic [7:0] ls_ymask = 8'h00;
    logic [2:0] hve_log [64];
    logic [2:0] l4pat [8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1};

    always @(negedge clk) begin
        if (acc_en) begin
            if (acc_cyc < 64) hve_log[acc_cyc] = hve_sync;
            if (pixel_req) pr_cnt = pr_cnt + 1;
            if (line_start) begin
                ls_cnt = ls_cnt + 1;
                ls_ymask[y[2:0]] = 1'b1;
            end
            acc_cyc = acc_cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_pixel_req"}, 32'(pixel_req), 0);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_line_start"}, 32'(line_start), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_hve"}, 32'(hve_sync), 32'h3);
    endtask

    initial begin
        logic found;
        logic gap;
        int   nt;
        int   fcyc;
        logic [10:0] px;
        logic [10:0] py;

        // First line of the first frame: {en, run, pr, x, y, ls, fs, hve}
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b1, 1'b1, 3'd3};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 11'd1, 11'd0, 1'b0, 1'b0, 3'd3};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 11'd2, 11'd0, 1'b0, 1'b0, 3'd7};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 11'd3, 11'd0, 1'b0, 1'b0, 3'd7};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 11'd4, 11'd0, 1'b0, 1'b0, 3'd7};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 11'd5, 11'd0, 1'b0, 1'b0, 3'd7};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 11'd6, 11'd0, 1'b0, 1'b0, 3'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 11'd7, 11'd0, 1'b0, 1'b0, 3'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 11'd0, 11'd1, 1'b1, 1'b0, 3'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 11'd1, 11'd1, 1'b0, 1'b0, 3'd3};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 11'd2, 11'd1, 1'b0, 1'b0, 3'd7};

        // Reset, then idle with enable low.
        repeat (3) tick();
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle%0d_hve", i), 32'(hve_sync), 32'h3);
            chk($sformatf("idle%0d_pixel_req", i), 32'(pixel_req), 0);
            chk($sformatf("idle%0d_running", i), 32'(running), 0);
        end

        // Start and first line, table driven.
        for (int i = 0; i < 11; i++) begin
            en = vecs[i].en;
            tick();
            if (i == 0) acc_en = 1'b1;
            chk($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].run));
            chk($sformatf("v%0d_pixel_req", i), 32'(pixel_req), 32'(vecs[i].pr));
            chk($sformatf("v%0d_x", i), 32'(x), 32'(vecs[i].x));
            chk($sformatf("v%0d_y", i), 32'(y), 32'(vecs[i].y));
            chk($sformatf("v%0d_line_start", i), 32'(line_start), 32'(vecs[i].ls));
            chk($sformatf("v%0d_frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
            chk($sformatf("v%0d_hve", i), 32'(hve_sync), 32'(vecs[i].hve));
        end

        // Rest of the frame up to the next frame_start.
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        acc_en = 1'b0;
        chk("frame2_seen", 32'(found), 1);
        chk("frame_period", 32'(acc_cyc), 48);
        chk("frame2_xy", {10'd0, x, y}, 0);
        chk("pixel_req_count", 32'(pr_cnt), 12);
        chk("line_start_count", 32'(ls_cnt), 3);
        chk("line_start_rows", 32'(ls_ymask), 32'h07);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("line4_hve_h%0d", k), 32'(hve_log[34+k]), 32'(l4pat[k]));
        end

        // Drop enable at v=1,h=3; frame must complete before stopping.
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (x == 11'd3 && y == 11'd1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("stop_point_seen", 32'(found), 1);
        en = 1'b0;
        found = 1'b0;
        nt = 0;
        px = x;
        py = y;
        for (int n = 0; n < 60; n++) begin
            px = x;
            py = y;
            tick();
            nt++;
            if (!running) begin
                found = 1'b1;
                break;
            end
        end
        chk("stop_reached", 32'(found), 1);
        chk("stop_cycles", 32'(nt), 37);
        chk("stop_last_x", 32'(px), 7);
        chk("stop_last_y", 32'(py), 5);
        chk("stop_x", 32'(x), 0);
        chk("stop_y", 32'(y), 0);
        chk("stop_pixel_req", 32'(pixel_req), 0);
        chk("drain0_hve", 32'(hve_sync), 32'h2);
        tick();
        chk("drain1_hve", 32'(hve_sync), 32'h3);
        chk("drain1_running", 32'(running), 0);
        tick();
        chk("drain2_hve", 32'(hve_sync), 32'h3);
        chk("drain2_frame_start", 32'(frame_start), 0);

        // Restart, then a short enable glitch mid-frame must not stop it.
        en = 1'b1;
        tick();
        chk("restart_running", 32'(running), 1);
        chk("restart_frame_start", 32'(frame_start), 1);
        chk("restart_xy", {10'd0, x, y}, 0);
        fcyc = 0;
        gap = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (x == 11'd0 && y == 11'd2) begin
                found = 1'b1;
                break;
            end
            tick();
            fcyc++;
        end
        chk("glitch_point_seen", 32'(found), 1);
        en = 1'b0;
        repeat (5) begin
            tick();
            fcyc++;
            if (!running) gap = 1'b1;
        end
        en = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            fcyc++;
            if (!running) gap = 1'b1;
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("glitch_next_frame", 32'(found), 1);
        chk("glitch_no_gap", 32'(gap), 0);
        chk("glitch_period", 32'(fcyc), 48);

        // Asynchronous reset mid-frame at v=2,h=2.
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (x == 11'd2 && y == 11'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("areset_point_seen", 32'(found), 1);
        chk("pre_reset_hve", 32'(hve_sync), 32'h7);
        chk("pre_reset_running", 32'(running), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        chk_reset_outputs("held_rst");
        rst_n = 1'b1;
        tick();
        chk("rst_release_running", 32'(running), 1);
        chk("rst_release_frame_start", 32'(frame_start), 1);
        chk("rst_release_xy", {10'd0, x, y}, 0);
        chk("rst_release_pixel_req", 32'(pixel_req), 1);
        chk("rst_release_hve", 32'(hve_sync), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
